// File: rtl/window_sequencer.sv
// window_sequencer
//   Sequences ADC samples into a hop-by-half windowing queue. Samples are
//   held for one cycle and then enqueued while there is room; once the queue
//   holds a full window, all DEPTH samples are read out. The queue then
//   rewinds its read pointer by SHIFT (half a window). This keeps the newest
//   half for the next window, so each later window needs only SHIFT new
//   samples.
//
// Ports
//   clock, reset        rising-edge clock, synchronous active-high reset
//   sample_valid/data   one-cycle ADC sample strobe and data
//   q_enqueue/q_dequeue/q_shift_back, q_data_in
//                       controls and write data for the external queue
//   q_data_out          queue read data, valid the cycle after q_dequeue
//   q_full/q_empty      queue status, only used to detect loss of sync
//   win_ready           downstream allows reads this cycle
//   win_valid/start/last, win_data
//                       window sample strobe, first/last flags, data
//   occupancy           tracked queue fill level, 0..DEPTH
//   overflow_count      dropped samples, saturating
//   desync              sticky: tracked level disagrees with queue status
module window_sequencer #(
    parameter int unsigned ADDRWIDTH = 12,
    parameter int unsigned WIDTH     = 12
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 sample_valid,
    input  logic [WIDTH-1:0]     sample_data,
    output logic                 q_enqueue,
    output logic                 q_dequeue,
    output logic                 q_shift_back,
    output logic [WIDTH-1:0]     q_data_in,
    input  logic [WIDTH-1:0]     q_data_out,
    input  logic                 q_full,
    input  logic                 q_empty,
    input  logic                 win_ready,
    output logic                 win_valid,
    output logic                 win_start,
    output logic                 win_last,
    output logic [WIDTH-1:0]     win_data,
    output logic [ADDRWIDTH:0]   occupancy,
    output logic [15:0]          overflow_count,
    output logic                 desync
);

    typedef enum logic [1:0] {S_FILL, S_READ, S_DRAIN, S_SHIFT} state_t;

    localparam logic [ADDRWIDTH:0] C_ONE   = {{ADDRWIDTH{1'b0}}, 1'b1};
    localparam logic [ADDRWIDTH:0] C_DEPTH = {1'b1, {ADDRWIDTH{1'b0}}};
    localparam logic [ADDRWIDTH:0] C_SHIFT = C_DEPTH >> 1;
    localparam logic [ADDRWIDTH:0] C_LAST  = C_DEPTH - C_ONE;

    state_t               r_state;
    state_t               w_state_next;
    logic [ADDRWIDTH:0]   r_rd_cnt;
    logic                 r_hold_valid;
    logic [WIDTH-1:0]     r_hold_data;
    logic [ADDRWIDTH:0]   r_occupancy;
    logic [15:0]          r_overflow;
    logic                 r_desync;
    logic                 r_win_valid;
    logic                 r_win_start;
    logic                 r_win_last;

    logic                 w_enq_ok;
    logic                 w_drop;
    logic [ADDRWIDTH+1:0] w_occ_plus_shift;
    logic                 w_room_after_shift;
    logic [ADDRWIDTH:0]   w_occ_next;

    // While a window is being read, only accept a sample if the level after
    // the coming rewind (which adds SHIFT back) still fits in the queue.
    assign w_occ_plus_shift   = {1'b0, r_occupancy} + {1'b0, C_SHIFT};
    assign w_room_after_shift = (w_occ_plus_shift < {1'b0, C_DEPTH});

    always_ff @(posedge clock) begin
        if (reset) r_state <= S_FILL;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_enq_ok     = 1'b0;
        q_dequeue    = 1'b0;
        q_shift_back = 1'b0;
        case (r_state)
            S_FILL: begin
                w_enq_ok = (r_occupancy < C_DEPTH);
                if (r_occupancy == C_DEPTH) w_state_next = S_READ;
            end
            S_READ: begin
                w_enq_ok  = w_room_after_shift;
                q_dequeue = win_ready && (r_rd_cnt < C_DEPTH);
                if (q_dequeue && (r_rd_cnt == C_LAST)) w_state_next = S_DRAIN;
            end
            S_DRAIN: begin
                w_enq_ok     = w_room_after_shift;
                w_state_next = S_SHIFT;
            end
            S_SHIFT: begin
                q_shift_back = 1'b1;
                w_state_next = S_FILL;
            end
            default: w_state_next = S_FILL;
        endcase
    end

    assign q_enqueue = r_hold_valid && w_enq_ok;
    assign q_data_in = r_hold_data;
    assign w_drop    = sample_valid && r_hold_valid && !q_enqueue;

    // Hold register: a new sample takes the slot if it is empty or is being
    // emptied this cycle; otherwise the new sample is the one dropped.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_hold_valid <= 1'b0;
            r_hold_data  <= '0;
        end else begin
            r_hold_valid <= sample_valid || (r_hold_valid && !q_enqueue);
            if (sample_valid && (!r_hold_valid || q_enqueue))
                r_hold_data <= sample_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_overflow <= '0;
        end else if (w_drop && (r_overflow != 16'hFFFF)) begin
            r_overflow <= r_overflow + 16'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset)                   r_rd_cnt <= '0;
        else if (r_state == S_SHIFT) r_rd_cnt <= '0;
        else if (q_dequeue)          r_rd_cnt <= r_rd_cnt + C_ONE;
    end

    // The rewind restores SHIFT entries that were read but not consumed.
    always_comb begin
        w_occ_next = r_occupancy;
        if (q_enqueue)    w_occ_next = w_occ_next + C_ONE;
        if (q_dequeue)    w_occ_next = w_occ_next - C_ONE;
        if (q_shift_back) w_occ_next = w_occ_next + C_SHIFT;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_occupancy <= '0;
            r_desync    <= 1'b0;
            r_win_valid <= 1'b0;
            r_win_start <= 1'b0;
            r_win_last  <= 1'b0;
        end else begin
            r_occupancy <= w_occ_next;
            if ((q_enqueue && q_full) || (q_dequeue && q_empty))
                r_desync <= 1'b1;
            r_win_valid <= q_dequeue;
            r_win_start <= q_dequeue && (r_rd_cnt == '0);
            r_win_last  <= q_dequeue && (r_rd_cnt == C_LAST);
        end
    end

    assign win_valid      = r_win_valid;
    assign win_start      = r_win_start;
    assign win_last       = r_win_last;
    assign win_data       = q_data_out;
    assign occupancy      = r_occupancy;
    assign overflow_count = r_overflow;
    assign desync         = r_desync;

endmodule

// File: tb/tb_window_sequencer.sv
// Testbench for window_sequencer with DEPTH=8 / SHIFT=4 and a behavioural
// rewindable queue attached to the queue ports.
module tb_window_sequencer;

    localparam int AW    = 3;
    localparam int W     = 12;
    localparam int DEPTH = 8;
    localparam int SHIFT = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          sample_valid = 1'b0;
    logic [W-1:0]  sample_data = '0;
    logic          q_enqueue, q_dequeue, q_shift_back;
    logic [W-1:0]  q_data_in;
    logic [W-1:0]  q_data_out;
    logic          q_full, q_empty;
    logic          win_ready = 1'b0;
    logic          win_valid, win_start, win_last;
    logic [W-1:0]  win_data;
    logic [AW:0]   occupancy;
    logic [15:0]   overflow_count;
    logic          desync;

    window_sequencer #(.ADDRWIDTH(AW), .WIDTH(W)) dut (
        .clock(clock), .reset(reset),
        .sample_valid(sample_valid), .sample_data(sample_data),
        .q_enqueue(q_enqueue), .q_dequeue(q_dequeue), .q_shift_back(q_shift_back),
        .q_data_in(q_data_in), .q_data_out(q_data_out),
        .q_full(q_full), .q_empty(q_empty),
        .win_ready(win_ready),
        .win_valid(win_valid), .win_start(win_start), .win_last(win_last),
        .win_data(win_data), .occupancy(occupancy),
        .overflow_count(overflow_count), .desync(desync)
    );

    always #5 clock = ~clock;

    // Rewindable circular queue stand-in.
    logic [W-1:0]  qmem [DEPTH];
    logic [AW-1:0] q_wr = '0, q_rd = '0;
    int            q_cnt = 0;
    always @(posedge clock) begin
        if (reset) begin
            q_wr <= '0; q_rd <= '0; q_cnt <= 0; q_data_out <= '0;
        end else begin
            if (q_enqueue) begin
                qmem[q_wr] <= q_data_in;
                q_wr <= q_wr + 3'd1;
            end
            if (q_dequeue) begin
                q_data_out <= qmem[q_rd];
                q_rd <= q_rd + 3'd1;
            end
            if (q_shift_back) q_rd <= q_rd - 3'd4;
            q_cnt <= q_cnt + (q_enqueue ? 1 : 0) - (q_dequeue ? 1 : 0)
                     + (q_shift_back ? SHIFT : 0);
        end
    end
    assign q_full  = (q_cnt == DEPTH);
    assign q_empty = (q_cnt == 0);

    int unsigned n_vec = 0, n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    typedef struct packed {
        logic [W-1:0] d;
        logic         s;
        logic         l;
    } exp_t;
    exp_t exp_q[$];

    // Expected window samples first..first+n-1, index 0 starts, index 7 ends.
    task automatic push_window(input int first, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.d = W'(first + i);
            e.s = (i == 0);
            e.l = (i == DEPTH - 1);
            exp_q.push_back(e);
        end
    endtask

    int unsigned cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int unsigned n_enq = 0, n_deq = 0, n_win = 0, n_shift = 0;
    int unsigned last_deq_cyc = 0, last_shift_cyc = 0, start_enq = 0;

    always @(negedge clock) begin
        if (!reset) begin
            if (q_enqueue) n_enq <= n_enq + 1;
            if (q_dequeue) begin
                n_deq <= n_deq + 1;
                last_deq_cyc <= cyc;
            end
            if (q_shift_back) begin
                n_shift <= n_shift + 1;
                last_shift_cyc <= cyc;
                check_eq("shift_exclusive", 32'(q_enqueue | q_dequeue), 32'd0);
            end
            if (win_valid) begin
                n_win <= n_win + 1;
                if (win_start) start_enq <= n_enq;
                if (exp_q.size() == 0) begin
                    check_eq("win_unexpected", 32'(exp_q.size()), 32'd1);
                end else begin
                    check_eq("win_data",  32'(win_data),  32'(exp_q[0].d));
                    check_eq("win_start", 32'(win_start), 32'(exp_q[0].s));
                    check_eq("win_last",  32'(win_last),  32'(exp_q[0].l));
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        sample_valid = 1'b0;
        tick();
        tick();
        check_eq({tag, "_strobes"}, 32'({q_enqueue, q_dequeue, q_shift_back,
                                        win_valid, win_start, win_last}), 32'd0);
        check_eq({tag, "_occ"}, 32'(occupancy), 32'd0);
        check_eq({tag, "_ovf"}, 32'(overflow_count), 32'd0);
        check_eq({tag, "_desync"}, 32'(desync), 32'd0);
        reset = 1'b0;
    endtask

    // Samples every 4 cycles; returns one cycle after the last is presented.
    task automatic feed(input int first, input int n);
        for (int i = 0; i < n; i++) begin
            sample_valid = 1'b1;
            sample_data  = W'(first + i);
            tick();
            sample_valid = 1'b0;
            if (i != n - 1) repeat (3) tick();
        end
    endtask

    task automatic wait_shift(input string tag, input int unsigned base);
        int unsigned k = 0;
        while (n_shift == base && k < 400) begin
            @(negedge clock); #1; k++;
        end
        check_eq(tag, n_shift - base, 32'd1);
    endtask

    task automatic wait_deq(input string tag, input int unsigned base, input int unsigned n);
        int unsigned k = 0;
        while (n_deq - base < n && k < 400) begin
            @(negedge clock); #1; k++;
        end
        check_eq(tag, n_deq - base, n);
    endtask

    task automatic wait_win(input string tag, input int unsigned base, input int unsigned n);
        int unsigned k = 0;
        while (n_win - base < n && k < 400) begin
            @(negedge clock); #1; k++;
        end
        check_eq(tag, n_win - base, n);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int unsigned base, sbase, wbase, snap;

        // Saturated input with no reads: fill stops at DEPTH, the rest drop.
        do_reset("rst_a");
        base = n_enq;
        for (int i = 0; i < 20; i++) begin
            sample_valid = 1'b1;
            sample_data  = W'(i + 1);
            tick();
        end
        sample_valid = 1'b0;
        tick();
        tick();
        check_eq("flood_enq", n_enq - base, 32'd8);
        check_eq("flood_hold", 32'(dut.r_hold_valid), 32'd1);
        check_eq("flood_ovf", 32'(overflow_count), 32'd11);
        check_eq("flood_desync", 32'(desync), 32'd0);
        check_eq("flood_occ", 32'(occupancy), 32'd8);

        // First window, then a sample during SHIFT, then the second window.
        do_reset("rst_b");
        win_ready = 1'b1;
        sbase = n_shift;
        wbase = n_win;
        push_window(1, 8);
        feed(1, 8);
        wait_shift("w1_shift_seen", sbase);
        check_eq("w1_shift_delay", last_shift_cyc - last_deq_cyc, 32'd2);
        snap = n_enq;
        sample_valid = 1'b1;
        sample_data  = W'(9);
        tick();
        sample_valid = 1'b0;
        @(negedge clock); #1;
        check_eq("enq_after_shift", 32'(q_enqueue), 32'd1);
        check_eq("shift_one_pulse", 32'(q_shift_back), 32'd0);
        check_eq("w1_occ_after", 32'(occupancy), 32'd4);
        check_eq("shift_no_drop", 32'(overflow_count), 32'd0);
        push_window(5, 8);
        tick();
        repeat (3) tick();
        feed(10, 3);
        sbase = n_shift;
        wait_shift("w2_shift_seen", sbase);
        check_eq("w2_new_enqs", start_enq - snap, 32'd4);
        check_eq("w2_win_count", n_win - wbase, 32'd16);
        tick();
        check_eq("w2_occ_after", 32'(occupancy), 32'd4);
        check_eq("w2_desync", 32'(desync), 32'd0);

        // Read stall after the third dequeue.
        do_reset("rst_c");
        win_ready = 1'b1;
        push_window(1, 8);
        base = n_deq;
        sbase = n_shift;
        wbase = n_win;
        feed(1, 8);
        wait_deq("stall_reach3", base, 3);
        tick();
        win_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clock); #1;
            check_eq("stall_deq", 32'(q_dequeue), 32'd0);
            check_eq("stall_rdcnt", 32'(dut.r_rd_cnt), 32'd3);
            check_eq("stall_wvalid", 32'(win_valid), (j == 0) ? 32'd1 : 32'd0);
        end
        tick();
        win_ready = 1'b1;
        wait_shift("stall_shift_seen", sbase);
        check_eq("stall_win_count", n_win - wbase, 32'd8);

        // Reset in the middle of a window.
        do_reset("rst_d");
        push_window(1, 5);
        wbase = n_win;
        feed(1, 8);
        wait_win("mid_reach5", wbase, 5);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clock); #1;
        check_eq("mid_strobes", 32'({q_enqueue, q_dequeue, q_shift_back,
                                     win_valid, win_start, win_last}), 32'd0);
        check_eq("mid_occ", 32'(occupancy), 32'd0);
        check_eq("mid_ovf", 32'(overflow_count), 32'd0);
        check_eq("mid_state", 32'(dut.r_state), 32'd0);
        check_eq("mid_sb_empty", 32'(exp_q.size()), 32'd0);
        tick();
        push_window(1, 8);
        wbase = n_win;
        sbase = n_shift;
        feed(1, 8);
        wait_shift("mid_fresh_shift", sbase);
        check_eq("mid_fresh_count", n_win - wbase, 32'd8);

        repeat (4) tick();
        check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
        check_eq("final_desync", 32'(desync), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/window_sequencer.md
WINDOW_SEQUENCER -- requirements
Module: window_sequencer

Interface
REQ-001 Parameter ADDRWIDTH, default 12, log2 of queue depth; DEPTH = 2^ADDRWIDTH samples per window, SHIFT = DEPTH/2 samples of hop.
REQ-002 Parameter WIDTH, default 12, sample width in bits.
REQ-003 clock  in  1  rising-edge clock for all state.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 sample_valid  in  1  one-cycle strobe, new ADC sample present.
REQ-006 sample_data  in  WIDTH  ADC sample, valid with sample_valid.
REQ-007 q_enqueue / q_dequeue / q_shift_back  out  1 each  drive the queue's enqueue, dequeue, shift_back inputs.
REQ-008 q_data_in  out  WIDTH  sample to queue data input.
REQ-009 q_data_out  in  WIDTH  queue read data, valid the cycle after q_dequeue.
REQ-010 q_full / q_empty  in  1 each  queue status, used only for the consistency check.
REQ-011 win_ready  in  1  downstream permits issuing reads this cycle.
REQ-012 win_valid / win_start / win_last  out  1 each  window sample strobe, first-sample flag, last-sample flag.
REQ-013 win_data  out  WIDTH  equals q_data_out (wire).
REQ-014 occupancy  out  ADDRWIDTH+1  tracked queue fill level, 0..DEPTH.
REQ-015 overflow_count  out  16  dropped-sample count, saturating at 0xFFFF.
REQ-016 desync  out  1  sticky error flag.

Function
REQ-017 Hold register (hold_valid, hold_data) captures sample_data on sample_valid; q_data_in = hold_data.
REQ-018 enq_ok = (state==FILL && occupancy<DEPTH) || (state in {READ,DRAIN} && occupancy+SHIFT<DEPTH); SHIFT state: enq_ok=0.
REQ-019 q_enqueue = hold_valid && enq_ok (combinational from registers); sample-to-enqueue latency 1 cycle minimum.
REQ-020 Same cycle: q_enqueue && sample_valid -> hold reloads with new sample; !q_enqueue && hold_valid && sample_valid -> new sample dropped, overflow_count +1; hold_valid clears on q_enqueue without new sample.
REQ-021 States FILL, READ, DRAIN, SHIFT; reset state FILL.
REQ-022 FILL -> READ when registered occupancy == DEPTH.
REQ-023 READ: q_dequeue = win_ready && rd_cnt<DEPTH; rd_cnt (ADDRWIDTH+1 bits) increments per dequeue; READ -> DRAIN on the cycle the DEPTH-th dequeue issues.
REQ-024 DRAIN lasts one cycle -> SHIFT; SHIFT lasts one cycle with q_shift_back=1, then -> FILL, rd_cnt cleared.
REQ-025 q_shift_back never coincides with q_enqueue or q_dequeue.
REQ-026 win_valid = q_dequeue registered (1-cycle latency); win_start with read index 0, win_last with index DEPTH-1; no output backpressure, downstream accepts every win_valid.
REQ-027 occupancy next = occupancy + q_enqueue - q_dequeue, plus SHIFT in SHIFT state; never exceeds DEPTH.
REQ-028 desync sets on (q_enqueue && q_full) or (q_dequeue && q_empty); cleared only by reset.

Reset
REQ-029 Reset clears state to FILL, rd_cnt, hold_valid, hold_data, occupancy, overflow_count, desync; q_enqueue, q_dequeue, q_shift_back, win_valid, win_start, win_last all 0 the following cycle.
REQ-030 Reset mid-window abandons the window with no further win_valid; queue shares the same reset.
REQ-031 Reset has priority over sample_valid and win_ready.

Verification (ADDRWIDTH=3: DEPTH=8, SHIFT=4)
REQ-032 After reset, samples 1..8 every 4 cycles, win_ready=1 -> 8 consecutive win_valid with data 1..8, win_start on 1, win_last on 8, then exactly one q_shift_back pulse two cycles after the last dequeue; occupancy=4 after.
REQ-033 Continue with samples 9..12 -> second window data 5..12, first window to second window start requires exactly 4 new enqueues.
REQ-034 win_ready held low 3 cycles after 3rd dequeue -> q_dequeue low those cycles, win_valid gap, data order 1..8 preserved, rd_cnt holds 3.
REQ-035 win_ready=0, sample_valid every cycle for 20 cycles from reset -> 8 enqueues, hold_valid=1, overflow_count=11, desync=0.
REQ-036 sample_valid on the SHIFT cycle -> held, q_enqueue asserted the cycle after SHIFT, no drop.
REQ-037 Reset asserted at the 5th win_valid -> next cycle all strobes 0, occupancy 0, overflow_count 0, state FILL; fresh 8 samples yield a full window.
